// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern pipeline: SPLIT, BARS, CHECKER, SCROLL.
// Optional red frame border when TPG_BORDER_EN is defined.
module vga_pattern_gen #(
    parameter int COLOR_W    = 4,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int ADDR_W     = 15,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FB_SHIFT   = 2,
    parameter int SPLIT_ADDR = 2047,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [X_W-1:0]     pixel_x,
    input  logic [Y_W-1:0]     pixel_y,
    input  logic               blank,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [1:0]         mode_sel,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               hs_out,
    output logic               vs_out,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [7:0]         frame_cnt
);

    typedef enum logic [1:0] {
        M_SPLIT   = 2'd0,
        M_BARS    = 2'd1,
        M_CHECKER = 2'd2,
        M_SCROLL  = 2'd3
    } mode_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic              blank;
        logic              hs;
        logic              vs;
        logic [ADDR_W-1:0] addr;
    } s1_t;

    function automatic logic [COLOR_W-1:0] split_pat();
        logic [COLOR_W-1:0] p;
        p = '0;
        for (int i = 0; i < COLOR_W; i++)
            p[i] = ((COLOR_W - 1 - i) % 2) == 0;
        return p;
    endfunction

    localparam logic [COLOR_W-1:0] MAX      = '1;
    localparam logic [COLOR_W-1:0] SPLIT_LO = split_pat();
    localparam logic [X_W-1:0]     H_LIM    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]     V_LIM    = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0]  ROW_W    = ADDR_W'(H_ACTIVE >> FB_SHIFT);
    localparam logic [ADDR_W-1:0]  SPLIT_A  = ADDR_W'(SPLIT_ADDR);
    localparam int                 BAR_W    = H_ACTIVE / 8;

    s1_t               s1;
    mode_t             mode_q;
    logic              vs_prev;
    logic              frame_edge;
    logic [ADDR_W-1:0] addr_c;

    logic               vis;
    logic [2:0]         bar;
    logic               chk;
    logic [X_W-1:0]     scroll_v;
    logic [COLOR_W-1:0] r_c, g_c, b_c;

    assign frame_edge = vs_prev & ~vs_in;
    assign addr_c = ADDR_W'(pixel_y >> FB_SHIFT) * ROW_W
                  + ADDR_W'(pixel_x >> FB_SHIFT);

    // Stage 1 plus the frame-rate state that gates pattern changes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1        <= '0;
            s1.hs     <= 1'b1;
            s1.vs     <= 1'b1;
            vs_prev   <= 1'b1;
            frame_cnt <= '0;
            mode_q    <= M_SPLIT;
        end else begin
            s1.x     <= pixel_x;
            s1.y     <= pixel_y;
            s1.blank <= blank;
            s1.hs    <= hs_in;
            s1.vs    <= vs_in;
            s1.addr  <= addr_c;
            vs_prev  <= vs_in;
            if (frame_edge) begin
                frame_cnt <= frame_cnt + 8'd1;
                mode_q    <= mode_t'(mode_sel);
            end
        end
    end

    always_comb begin
        vis      = s1.blank && (s1.x < H_LIM) && (s1.y < V_LIM);
        bar      = '0;
        for (int k = 1; k < 8; k++)
            if ({{(32-X_W){1'b0}}, s1.x} >= 32'(k * BAR_W))
                bar = bar + 3'd1;
        chk      = 1'((s1.x >> CHECK_LOG2) ^ (s1.y >> CHECK_LOG2));
        scroll_v = s1.x + X_W'(frame_cnt);
        r_c      = '0;
        g_c      = '0;
        b_c      = '0;
        unique case (mode_q)
            M_SPLIT: begin
                r_c = (s1.addr < SPLIT_A) ? MAX : SPLIT_LO;
                g_c = r_c;
                b_c = r_c;
            end
            M_BARS: begin
                r_c = bar[2] ? MAX : '0;
                g_c = bar[1] ? MAX : '0;
                b_c = bar[0] ? MAX : '0;
            end
            M_CHECKER: begin
                r_c = chk ? MAX : '0;
                g_c = r_c;
                b_c = r_c;
            end
            M_SCROLL: begin
                r_c = COLOR_W'(scroll_v >> 4);
                g_c = r_c;
                b_c = r_c;
            end
        endcase
`ifdef TPG_BORDER_EN
        if (s1.x == '0 || s1.x == H_LIM - 1'b1 ||
            s1.y == '0 || s1.y == V_LIM - 1'b1) begin
            r_c = MAX;
            g_c = '0;
            b_c = '0;
        end
`endif
        if (!vis) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Stage 2: everything leaves the block from flops
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            pixel_addr <= '0;
            hs_out     <= 1'b1;
            vs_out     <= 1'b1;
        end else begin
            VGA_R      <= r_c;
            VGA_G      <= g_c;
            VGA_B      <= b_c;
            pixel_addr <= vis ? s1.addr : '0;
            hs_out     <= s1.hs;
            vs_out     <= s1.vs;
        end
    end

endmodule
